hilo_muldiv_unit: RTL and testbench

//   Iterative multiply/divide unit that owns the HI/LO register pair. It is the writer side
//   of the HI/LO interface; EX is the reader (MFHI/MFLO).
//   EX issues MULT/MULTU/DIV/DIVU/MTHI/MTLO with a Start pulse. This unit computes over 33 cycles
//   and signals Busy/Done so the core stalls until HI/LO are valid.

---
 rtl/mips_defs.sv | 21 ++
 rtl/muldiv_sign_fix.sv | 32 +++
 rtl/hilo_muldiv_unit.sv | 120 ++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// Shared MIPS definitions for the HI/LO multiply/divide unit.
package mips_defs;

  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  function automatic logic is_signed_op(input logic [5:0] funct);
    return (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Turns the unsigned magnitude result of the iterative core into final HI/LO values.
module muldiv_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic               sign_a,
  input  logic               sign_b,
  input  logic               dz,
  input  logic [2*WIDTH-1:0] raw,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;

  always_comb begin
    prod = (sign_a ^ sign_b) ? -raw : raw;
    // Remainder follows the dividend; on divide-by-zero it already holds |dividend|.
    rem  = sign_a ? -raw[2*WIDTH-1:WIDTH] : raw[2*WIDTH-1:WIDTH];
    quo  = (sign_a ^ sign_b) ? -raw[WIDTH-1:0] : raw[WIDTH-1:0];
    if (is_div) begin
      hi = rem;
      lo = dz ? '1 : quo;
    end else begin
      hi = prod[2*WIDTH-1:WIDTH];
      lo = prod[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO; 33-cycle latency for MULT/MULTU/DIV/DIVU.
module hilo_muldiv_unit
  import mips_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [5:0]       Funct,
  input  logic [WIDTH-1:0] Rdata1,
  input  logic [WIDTH-1:0] Rdata2,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH) + 1;

  md_state_e          state_reg;
  logic [CW-1:0]      cnt_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   opb_reg;
  logic               is_div_reg;
  logic               sign_a_reg;
  logic               sign_b_reg;
  logic               dz_reg;

  logic               sa, sb;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     add_sum, rem_shift, sub_diff;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  always_comb begin
    sa    = is_signed_op(Funct) & Rdata1[WIDTH-1];
    sb    = is_signed_op(Funct) & Rdata2[WIDTH-1];
    abs_a = sa ? -Rdata1 : Rdata1;
    abs_b = sb ? -Rdata2 : Rdata2;
  end

  // acc holds {partial product, multiplier} for mul and {remainder, dividend/quotient} for div.
  always_comb begin
    add_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, opb_reg} : '0);
    rem_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    sub_diff  = rem_shift - {1'b0, opb_reg};
    if (!is_div_reg)
      acc_next = {add_sum, acc_reg[WIDTH-1:1]};
    else if (!sub_diff[WIDTH])
      acc_next = {sub_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
    else
      acc_next = {rem_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
  end

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .is_div (is_div_reg),
    .sign_a (sign_a_reg),
    .sign_b (sign_b_reg),
    .dz     (dz_reg),
    .raw    (acc_reg),
    .hi     (fix_hi),
    .lo     (fix_lo)
  );

  assign Busy = (state_reg != MD_IDLE);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg  <= MD_IDLE;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      opb_reg    <= '0;
      is_div_reg <= 1'b0;
      sign_a_reg <= 1'b0;
      sign_b_reg <= 1'b0;
      dz_reg     <= 1'b0;
      Done       <= 1'b0;
      HI         <= '0;
      LO         <= '0;
    end else begin
      Done <= 1'b0;
      case (state_reg)
        MD_IDLE: begin
          if (Start) begin
            case (Funct)
              FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: begin
                state_reg  <= MD_RUN;
                cnt_reg    <= '0;
                acc_reg    <= {{WIDTH{1'b0}}, abs_a};
                opb_reg    <= abs_b;
                is_div_reg <= (Funct == FUNCT_DIV) || (Funct == FUNCT_DIVU);
                sign_a_reg <= sa;
                sign_b_reg <= sb;
                dz_reg     <= (Rdata2 == '0);
              end
              FUNCT_MTHI: HI <= Rdata1;
              FUNCT_MTLO: LO <= Rdata1;
              default: ;
            endcase
          end
        end
        MD_RUN: begin
          acc_reg <= acc_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(WIDTH - 1))
            state_reg <= MD_FIX;
        end
        MD_FIX: begin
          HI        <= fix_hi;
          LO        <= fix_lo;
          Done      <= 1'b1;
          state_reg <= MD_IDLE;
        end
        default: state_reg <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: directed corner cases plus randomized mul/div ops.
module tb_hilo_muldiv_unit;

  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        Start = 1'b0;
  logic [5:0]  Funct = 6'h0;
  logic [31:0] Rdata1 = '0;
  logic [31:0] Rdata2 = '0;
  logic        Busy, Done;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int done_exp = 0;
  logic [63:0] exp_q[$];
  logic [31:0] cur_hi = '0, cur_lo = '0;

  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Funct(Funct),
    .Rdata1(Rdata1), .Rdata2(Rdata2),
    .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural meaning of each op.
  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sp, sq, sr;
    logic [63:0] up;
    case (f)
      F_MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        return sp;
      end
      F_MULTU: begin
        up = {32'h0, a} * {32'h0, b};
        return up;
      end
      F_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        sq = longint'($signed(a)) / longint'($signed(b));
        sr = longint'($signed(a)) % longint'($signed(b));
        return {sr[31:0], sq[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Monitor: every Done pulse consumes one expected {HI,LO}.
  always @(negedge CLK) begin
    if (RST && Done) begin
      logic [63:0] e;
      done_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got Done=1 expected no pending op");
      end else begin
        e = exp_q.pop_front();
        check("result_hi", HI, e[63:32]);
        check("result_lo", LO, e[31:0]);
      end
    end
  end

  // Issue at a negedge; returns at the first negedge with Busy low (the Done cycle).
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int inject, input bit check_busy);
    int n;
    logic [63:0] e;
    e = model(f, a, b);
    exp_q.push_back(e);
    done_exp++;
    cur_hi = e[63:32];
    cur_lo = e[31:0];
    Start = 1'b1; Funct = f; Rdata1 = a; Rdata2 = b;
    @(negedge CLK);
    Start = 1'b0;
    n = 0;
    while (Busy && n < 100) begin
      n++;
      if (n == inject) begin
        Start = 1'b1; Funct = F_MTLO; Rdata1 = 32'hAA;
      end else begin
        Start = 1'b0;
      end
      @(negedge CLK);
    end
    Start = 1'b0;
    if (check_busy) check("busy_cycles", n, 33);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 20);
      4: return -$urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [5:0] ops[4];
    ops[0] = F_MULT; ops[1] = F_MULTU; ops[2] = F_DIV; ops[3] = F_DIVU;

    repeat (2) @(negedge CLK);
    check("reset_hi", HI, 0);
    check("reset_lo", LO, 0);
    check("reset_busy", {31'b0, Busy}, 0);
    check("reset_done", {31'b0, Done}, 0);
    RST = 1'b1;
    @(negedge CLK);

    run_op(F_MULT, 7, 5, 0, 1'b1);
    run_op(F_MULT, -3, 4, 0, 1'b1);
    run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b1);
    run_op(F_DIV, -7, 2, 0, 1'b1);
    run_op(F_DIVU, 100, 7, 0, 1'b1);
    run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1);
    run_op(F_DIV, 32'h1234, 0, 0, 1'b1);
    run_op(F_DIV, -32'h1234, 0, 0, 1'b1);
    run_op(F_MULT, 2, 3, 5, 1'b1);
    @(negedge CLK);
    check("mtlo_ignored_busy", LO, 32'd6);

    // MTLO / MTHI while idle: immediate write, no Busy, no Done.
    Start = 1'b1; Funct = F_MTLO; Rdata1 = 32'hAA;
    @(negedge CLK);
    Start = 1'b0;
    check("mtlo_lo", LO, 32'hAA);
    check("mtlo_hi_kept", HI, cur_hi);
    check("mtlo_busy", {31'b0, Busy}, 0);
    check("mtlo_done", {31'b0, Done}, 0);
    Start = 1'b1; Funct = F_MTHI; Rdata1 = 32'h5555_1234;
    @(negedge CLK);
    Start = 1'b0;
    check("mthi_hi", HI, 32'h5555_1234);
    check("mthi_lo_kept", LO, 32'hAA);

    // Unlisted funct is ignored.
    Start = 1'b1; Funct = 6'h20; Rdata1 = 32'hDEAD; Rdata2 = 32'h1;
    @(negedge CLK);
    Start = 1'b0;
    check("bad_funct_busy", {31'b0, Busy}, 0);
    check("bad_funct_hi", HI, 32'h5555_1234);
    check("bad_funct_lo", LO, 32'hAA);

    // Asynchronous reset mid-DIVU aborts it.
    Start = 1'b1; Funct = F_DIVU; Rdata1 = 32'd1000; Rdata2 = 32'd3;
    @(negedge CLK);
    Start = 1'b0;
    repeat (9) @(negedge CLK);
    check("abort_busy_before", {31'b0, Busy}, 1);
    #2 RST = 1'b0;
    #1;
    check("abort_hi", HI, 0);
    check("abort_lo", LO, 0);
    check("abort_busy", {31'b0, Busy}, 0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    run_op(F_MULT, 9, 9, 0, 1'b1);

    // Back-to-back random ops, each issued in the previous op's Done cycle.
    for (int i = 0; i < 40; i++)
      run_op(ops[$urandom_range(0, 3)], pick(), pick(), 0, 1'b1);

    repeat (3) @(negedge CLK);
    check("done_count", done_seen, done_exp);
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
